// File: rtl/ex_stage_if.sv
// Execute-stage op encodings and the decode->EX / EX->MEM bundle of the execute stage.
// Package first, then the interface that carries every non-clock/reset port.
package ex_stage_pkg;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned ALUOP_W = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned DREG_W  = 64;

  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [ALUOP_W-1:0] EXE_CLZ_OP   = 8'b1011_0000;
  localparam logic [ALUOP_W-1:0] EXE_CLO_OP   = 8'b1011_0001;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MUL        = 3'b101;
endpackage

interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ALUOP_W-1:0]  aluop_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [REG_W-1:0]    reg1_i;
  logic [REG_W-1:0]    reg2_i;
  logic [ADDR_W-1:0]   wd_i;
  logic                wreg_i;
  logic [REG_W-1:0]    hi_i;
  logic [REG_W-1:0]    lo_i;
  logic                mem_whilo_i;
  logic [REG_W-1:0]    mem_hi_i;
  logic [REG_W-1:0]    mem_lo_i;
  logic                wb_whilo_i;
  logic [REG_W-1:0]    wb_hi_i;
  logic [REG_W-1:0]    wb_lo_i;
  logic                stall_i;
  logic [ADDR_W-1:0]   wd_o;
  logic                wreg_o;
  logic [REG_W-1:0]    wdata_o;
  logic                whilo_o;
  logic [REG_W-1:0]    hi_o;
  logic [REG_W-1:0]    lo_o;
  logic                stallreq;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i, stall_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i, stall_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, HI/LO forwarding and the two-cycle multiply-accumulate.
// Define EX_OVF_SUPPRESS_EN to drop the register write on signed ADD/ADDI/SUB overflow.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DREG_W-1:0] acc_tmp, acc_nxt;

  logic [REG_W-1:0]  r1, r2, hi_cur, lo_cur;
  logic [REG_W-1:0]  sum, diff, lz_src;
  logic [REG_W-1:0]  logic_res, shift_res, move_res, arith_res, wdata_res;
  logic [DREG_W-1:0] op1_ext, op2_ext, prod, madd_term, acc_sum;
  logic [5:0]        lz_cnt;
  logic [4:0]        sh;
  logic              is_madd, is_msub, mul_signed, ovf;

  assign r1 = bus.reg1_i;
  assign r2 = bus.reg2_i;
  assign sh = bus.reg1_i[4:0];

  // Youngest in-flight HI/LO write wins.
  always_comb begin
    if (bus.mem_whilo_i) begin
      hi_cur = bus.mem_hi_i;
      lo_cur = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_cur = bus.wb_hi_i;
      lo_cur = bus.wb_lo_i;
    end else begin
      hi_cur = bus.hi_i;
      lo_cur = bus.lo_i;
    end
  end

  assign is_madd    = bus.aluop_i inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
  assign is_msub    = bus.aluop_i inside {EXE_MSUB_OP, EXE_MSUBU_OP};
  assign mul_signed = bus.aluop_i inside {EXE_MULT_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MSUB_OP};

  // One shared multiplier; signedness comes from how the operands are extended.
  assign op1_ext   = mul_signed ? {{REG_W{r1[REG_W-1]}}, r1} : {{REG_W{1'b0}}, r1};
  assign op2_ext   = mul_signed ? {{REG_W{r2[REG_W-1]}}, r2} : {{REG_W{1'b0}}, r2};
  assign prod      = op1_ext * op2_ext;
  assign madd_term = is_msub ? (~prod + 64'd1) : prod;
  assign acc_sum   = {hi_cur, lo_cur} + acc_tmp;

  assign sum  = r1 + r2;
  assign diff = r1 - r2;

`ifdef EX_OVF_SUPPRESS_EN
  always_comb begin
    ovf = 1'b0;
    if (bus.aluop_i inside {EXE_ADD_OP, EXE_ADDI_OP})
      ovf = (r1[REG_W-1] == r2[REG_W-1]) && (sum[REG_W-1] != r1[REG_W-1]);
    else if (bus.aluop_i == EXE_SUB_OP)
      ovf = (r1[REG_W-1] != r2[REG_W-1]) && (diff[REG_W-1] != r1[REG_W-1]);
  end
`else
  assign ovf = 1'b0;
`endif

  // CLO counts leading ones as leading zeros of the complement.
  always_comb begin
    lz_src = (bus.aluop_i == EXE_CLO_OP) ? ~r1 : r1;
    lz_cnt = 6'd32;
    for (int i = 0; i < 32; i++)
      if (lz_src[i]) lz_cnt = 6'(31 - i);
  end

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    arith_res = '0;
    case (bus.aluop_i)
      EXE_OR_OP:   logic_res = r1 | r2;
      EXE_AND_OP:  logic_res = r1 & r2;
      EXE_XOR_OP:  logic_res = r1 ^ r2;
      EXE_NOR_OP:  logic_res = ~(r1 | r2);
      EXE_SLL_OP:  shift_res = r2 << sh;
      EXE_SRL_OP:  shift_res = r2 >> sh;
      EXE_SRA_OP:  shift_res = 32'($signed(r2) >>> sh);
      EXE_MFHI_OP: move_res  = hi_cur;
      EXE_MFLO_OP: move_res  = lo_cur;
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = r1;
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: arith_res = sum;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {31'b0, $signed(r1) < $signed(r2)};
      EXE_SLTU_OP: arith_res = {31'b0, r1 < r2};
      EXE_CLZ_OP, EXE_CLO_OP: arith_res = 32'(lz_cnt);
      default: ;
    endcase
  end

  always_comb begin
    case (bus.alusel_i)
      EXE_RES_LOGIC:      wdata_res = logic_res;
      EXE_RES_SHIFT:      wdata_res = shift_res;
      EXE_RES_MOVE:       wdata_res = move_res;
      EXE_RES_ARITHMETIC: wdata_res = arith_res;
      EXE_RES_MUL:        wdata_res = prod[REG_W-1:0];
      EXE_RES_NOP:        wdata_res = '0;
      default:            wdata_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_tmp <= '0;
    end else begin
      state   <= state_nxt;
      acc_tmp <= acc_nxt;
    end
  end

  // Capture the product in IDLE, then leave ACC once the stage is released or flushed.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_tmp;
    unique case (state)
      IDLE: if (is_madd && !bus.stall_i) begin
        state_nxt = ACC;
        acc_nxt   = madd_term;
      end
      ACC:  if (!is_madd || !bus.stall_i) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wd_o     = '0;
    bus.wreg_o   = 1'b0;
    bus.wdata_o  = '0;
    bus.whilo_o  = 1'b0;
    bus.hi_o     = '0;
    bus.lo_o     = '0;
    bus.stallreq = 1'b0;
    if (!rst) begin
      bus.wd_o    = bus.wd_i;
      bus.wreg_o  = bus.wreg_i & ~ovf;
      bus.wdata_o = wdata_res;
      case (bus.aluop_i)
        EXE_MTHI_OP: begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = r1;
          bus.lo_o    = lo_cur;
        end
        EXE_MTLO_OP: begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = hi_cur;
          bus.lo_o    = r1;
        end
        EXE_MULT_OP, EXE_MULTU_OP: begin
          bus.whilo_o = 1'b1;
          {bus.hi_o, bus.lo_o} = prod;
        end
        default: ;
      endcase
      if (is_madd) begin
        if (state == IDLE) begin
          bus.stallreq = 1'b1;
        end else begin
          bus.whilo_o = 1'b1;
          {bus.hi_o, bus.lo_o} = acc_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Randomised scoreboard bench for ex_stage with directed corner cases up front.
// Build with EX_OVF_SUPPRESS_EN defined to exercise the overflow-suppression variant.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stallreq;
  } exp_t;

  logic clk;
  logic rst;
  ex_stage_if bus();

  ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference state: is an accumulate result owed next cycle, and its addend.
  bit          pend = 1'b0;
  logic [63:0] pend_val = '0;

  logic [7:0] op_tab[30];

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP: return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            return EXE_RES_SHIFT;
      EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVZ_OP, EXE_MOVN_OP: return EXE_RES_MOVE;
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP, EXE_SUB_OP, EXE_SUBU_OP,
      EXE_SLT_OP, EXE_SLTU_OP, EXE_CLZ_OP, EXE_CLO_OP: return EXE_RES_ARITHMETIC;
      EXE_MUL_OP: return EXE_RES_MUL;
      default:    return EXE_RES_NOP;
    endcase
  endfunction

  function automatic void check(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, id, act, req);
    end
  endfunction

  task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.aluop_i  = op;
    bus.alusel_i = sel_of(op);
    bus.reg1_i   = a;
    bus.reg2_i   = b;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance one clock.
  task automatic step();
    exp_t        e;
    logic [7:0]  op;
    logic [31:0] r1, r2, fhi, flo, res, v, ones;
    logic [63:0] p;
    longint      a, b, s;
    int          n;
    bit          madd, sgn, ovf;
    e    = '0;
    op   = bus.aluop_i;
    r1   = bus.reg1_i;
    r2   = bus.reg2_i;
    ones = 32'hFFFF_FFFF;
    a    = longint'($signed(r1));
    b    = longint'($signed(r2));
    ovf  = 1'b0;
    res  = '0;
    fhi  = bus.mem_whilo_i ? bus.mem_hi_i : (bus.wb_whilo_i ? bus.wb_hi_i : bus.hi_i);
    flo  = bus.mem_whilo_i ? bus.mem_lo_i : (bus.wb_whilo_i ? bus.wb_lo_i : bus.lo_i);
    madd = op inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
    sgn  = op inside {EXE_MULT_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MSUB_OP};
    p    = sgn ? 64'(a * b) : ({32'b0, r1} * {32'b0, r2});
    if (op inside {EXE_MSUB_OP, EXE_MSUBU_OP}) p = -p;
    case (op)
      EXE_OR_OP:   res = r1 | r2;
      EXE_AND_OP:  res = r1 & r2;
      EXE_XOR_OP:  res = r1 ^ r2;
      EXE_NOR_OP:  res = ~(r1 | r2);
      EXE_SLL_OP:  res = r2 << r1[4:0];
      EXE_SRL_OP:  res = r2 >> r1[4:0];
      EXE_SRA_OP:  res = (r2 >> r1[4:0]) | (r2[31] ? ~(ones >> r1[4:0]) : 32'h0);
      EXE_MFHI_OP: res = fhi;
      EXE_MFLO_OP: res = flo;
      EXE_MOVZ_OP, EXE_MOVN_OP: res = r1;
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: begin
        s   = a + b;
        res = 32'(s);
        ovf = (op inside {EXE_ADD_OP, EXE_ADDI_OP}) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      EXE_SUB_OP, EXE_SUBU_OP: begin
        s   = a - b;
        res = 32'(s);
        ovf = (op == EXE_SUB_OP) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      EXE_SLT_OP:  res = (a < b) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: res = (r1 < r2) ? 32'd1 : 32'd0;
      EXE_CLZ_OP, EXE_CLO_OP: begin
        v = (op == EXE_CLO_OP) ? ~r1 : r1;
        n = 0;
        while (v != 0) begin
          v = v >> 1;
          n++;
        end
        res = 32'(32 - n);
      end
      EXE_MUL_OP:  res = p[31:0];
      default:     res = '0;
    endcase
`ifndef EX_OVF_SUPPRESS_EN
    ovf = 1'b0;
`endif
    if (rst) begin
      pend = 1'b0;
      pend_val = '0;
    end else begin
      e.wd    = bus.wd_i;
      e.wreg  = bus.wreg_i && !ovf;
      e.wdata = res;
      if (op == EXE_MTHI_OP) begin e.whilo = 1'b1; e.hi = r1; e.lo = flo; end
      if (op == EXE_MTLO_OP) begin e.whilo = 1'b1; e.hi = fhi; e.lo = r1; end
      if (op inside {EXE_MULT_OP, EXE_MULTU_OP}) begin e.whilo = 1'b1; {e.hi, e.lo} = p; end
      if (madd && pend) begin
        e.whilo = 1'b1;
        {e.hi, e.lo} = {fhi, flo} + pend_val;
        pend = bus.stall_i;
      end else if (madd) begin
        e.stallreq = 1'b1;
        if (!bus.stall_i) begin
          pend = 1'b1;
          pend_val = p;
        end
      end else begin
        pend = 1'b0;
      end
    end
    exp_q.push_back(e);
    id_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so compare mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      check("wd_o",     id, 32'(bus.wd_o),     32'(e.wd));
      check("wreg_o",   id, 32'(bus.wreg_o),   32'(e.wreg));
      check("wdata_o",  id, bus.wdata_o,       e.wdata);
      check("whilo_o",  id, 32'(bus.whilo_o),  32'(e.whilo));
      check("hi_o",     id, bus.hi_o,          e.hi);
      check("lo_o",     id, bus.lo_o,          e.lo);
      check("stallreq", id, 32'(bus.stallreq), 32'(e.stallreq));
    end
  end

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    op_tab = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
               EXE_SRA_OP, EXE_MOVZ_OP, EXE_MOVN_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP,
               EXE_MTLO_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP,
               EXE_SUBU_OP, EXE_ADDI_OP, EXE_ADDIU_OP, EXE_CLZ_OP, EXE_CLO_OP, EXE_MULT_OP,
               EXE_MULTU_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
    rst = 1'b1;
    set_op(EXE_OR_OP, 32'hF0F0_0000, 32'h0000_0F0F);
    bus.wd_i = 5'd7;  bus.wreg_i = 1'b1;  bus.stall_i = 1'b0;
    bus.hi_i = '0;    bus.lo_i = '0;
    bus.mem_whilo_i = 1'b0; bus.mem_hi_i = '0; bus.mem_lo_i = '0;
    bus.wb_whilo_i  = 1'b0; bus.wb_hi_i  = '0; bus.wb_lo_i  = '0;
    @(posedge clk);
    #1;

    step();
    rst = 1'b0;
    step();
    set_op(EXE_SRA_OP, 32'd4, 32'h8000_0000);  step();
    set_op(EXE_CLZ_OP, 32'h0001_0000, 32'h0);  step();
    set_op(EXE_SLT_OP, 32'hFFFF_FFFF, 32'h1);  step();

    set_op(EXE_MFHI_OP, 32'h0, 32'h0);
    bus.hi_i = 32'h11; bus.mem_whilo_i = 1'b1; bus.mem_hi_i = 32'h22;
    bus.wb_whilo_i = 1'b1; bus.wb_hi_i = 32'h33;
    step();
    bus.mem_whilo_i = 1'b0;
    step();
    bus.wb_whilo_i = 1'b0;

    bus.hi_i = 32'h0; bus.lo_i = 32'h5; bus.wreg_i = 1'b0;
    set_op(EXE_MADD_OP, 32'hFFFF_FFFF, 32'd3);
    step(); step();
    step();
    bus.stall_i = 1'b1; step(); step();
    bus.stall_i = 1'b0; step();
    set_op(8'h00, 32'h0, 32'h0); step();

    bus.lo_i = 32'h0;
    set_op(EXE_MSUBU_OP, 32'd2, 32'd3);
    step(); step();
    step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    set_op(8'h00, 32'h0, 32'h0); step();

    bus.wreg_i = 1'b1;
    set_op(EXE_ADD_OP,  32'h7FFF_FFFF, 32'h1); step();
    set_op(EXE_ADDU_OP, 32'h7FFF_FFFF, 32'h1); step();
    set_op(EXE_SUB_OP,  32'h8000_0000, 32'h1); step();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      set_op(op_tab[$urandom_range(0, 29)], rand_opnd(), rand_opnd());
      bus.wd_i        = 5'($urandom);
      bus.wreg_i      = 1'($urandom);
      bus.stall_i     = ($urandom_range(0, 3) == 0);
      bus.hi_i        = rand_opnd();
      bus.lo_i        = rand_opnd();
      bus.mem_whilo_i = ($urandom_range(0, 3) == 0);
      bus.mem_hi_i    = $urandom;
      bus.mem_lo_i    = $urandom;
      bus.wb_whilo_i  = ($urandom_range(0, 3) == 0);
      bus.wb_hi_i     = $urandom;
      bus.wb_lo_i     = $urandom;
      step();
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions never compared, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
